// File: rtl/handshake_pkg.sv
// Shared definitions for the valid/ready handshake stages: default sizes,
// pointer/count width helpers and a constant-evaluable clog2.
package handshake_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 4;

    // Ceiling log2, usable in parameter defaults.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 32'sd1; v > 32'sd0; v = v >>> 1) begin
            result = result + 32'sd1;
        end
        return result;
    endfunction

    function automatic int ptr_w(input int depth);
        return clog2(depth);
    endfunction

    function automatic int count_w(input int depth);
        return clog2(depth) + 32'sd1;
    endfunction

    localparam int DEFAULT_ADDR_W = ptr_w(DEFAULT_DEPTH);

    typedef logic [DEFAULT_ADDR_W-1:0] ptr_t;
    typedef logic [count_w(DEFAULT_DEPTH)-1:0] count_t;

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping ADDR_W-bit pointer register with increment enable; wraps
// modulo 2**ADDR_W, which equals the FIFO depth.
module fifo_ptr
    import handshake_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              INC,
    output logic [ADDR_W-1:0] PTR
);

    logic [ADDR_W-1:0] ptr_r;

    // Pointer register: clear on reset, advance by one when enabled.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ptr_r <= '0;
        end else if (INC) begin
            ptr_r <= ptr_r + ADDR_W'(1);
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign PTR = ptr_r;

endmodule

// File: rtl/handshake_fifo.sv
// First-word fall-through FIFO for valid/ready streams. Define
// HANDSHAKE_FIFO_LEVEL_EN to expose the occupancy on the LEVEL port.
module handshake_fifo
    import handshake_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             VALID_UP,
    output logic             READY_UP,
    input  logic [WIDTH-1:0] DATA_UP,
    output logic             VALID_DOWN,
    input  logic             READY_DOWN,
`ifdef HANDSHAKE_FIFO_LEVEL_EN
    output logic [WIDTH-1:0] DATA_DOWN,
    output logic [ADDR_W:0]  LEVEL
`else
    output logic [WIDTH-1:0] DATA_DOWN
`endif
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0]  mem_r [DEPTH];
    logic [ADDR_W:0]   count_r;
    logic [ADDR_W-1:0] wr_ptr_s;
    logic [ADDR_W-1:0] rd_ptr_s;
    logic              push_s;
    logic              pop_s;
    logic              ready_up_s;
    logic              valid_down_s;

    // Flags come from registered count only, so READY_DOWN never reaches READY_UP.
    assign ready_up_s   = (count_r != FULL_COUNT);
    assign valid_down_s = (count_r != '0);
    assign push_s       = VALID_UP && ready_up_s;
    assign pop_s        = valid_down_s && READY_DOWN;

    fifo_ptr #(.ADDR_W(ADDR_W)) u_wr_ptr (
        .CLK   (CLK),
        .RESET (RESET),
        .INC   (push_s),
        .PTR   (wr_ptr_s)
    );

    fifo_ptr #(.ADDR_W(ADDR_W)) u_rd_ptr (
        .CLK   (CLK),
        .RESET (RESET),
        .INC   (pop_s),
        .PTR   (rd_ptr_s)
    );

    // Storage array: cleared on reset so DATA_DOWN reads zero afterwards.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= WIDTH'(0);
            end
        end else if (push_s) begin
            mem_r[wr_ptr_s] <= DATA_UP;
        end else begin
            mem_r[wr_ptr_s] <= mem_r[wr_ptr_s];
        end
    end

    // Occupancy counter; simultaneous push and pop leaves it unchanged.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            count_r <= '0;
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (ADDR_W + 1)'(1);
                2'b01:   count_r <= count_r - (ADDR_W + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign READY_UP   = ready_up_s;
    assign VALID_DOWN = valid_down_s;
    assign DATA_DOWN  = mem_r[rd_ptr_s];

`ifdef HANDSHAKE_FIFO_LEVEL_EN
    assign LEVEL = count_r;
`else
`endif

endmodule

// File: tb/tb_handshake_fifo.sv
// Directed self-checking bench for handshake_fifo (WIDTH=8, DEPTH=4).
module tb_handshake_fifo;

    logic       CLK;
    logic       RESET;
    logic       VALID_UP;
    logic       READY_UP;
    logic [7:0] DATA_UP;
    logic       VALID_DOWN;
    logic       READY_DOWN;
    logic [7:0] DATA_DOWN;
`ifdef HANDSHAKE_FIFO_LEVEL_EN
    logic [2:0] LEVEL;
`endif

    int errors;
    int checks;

    handshake_fifo #(.WIDTH(8), .DEPTH(4)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .VALID_UP   (VALID_UP),
        .READY_UP   (READY_UP),
        .DATA_UP    (DATA_UP),
        .VALID_DOWN (VALID_DOWN),
        .READY_DOWN (READY_DOWN),
`ifdef HANDSHAKE_FIFO_LEVEL_EN
        .DATA_DOWN  (DATA_DOWN),
        .LEVEL      (LEVEL)
`else
        .DATA_DOWN  (DATA_DOWN)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1; VALID_UP = 1'b1; DATA_UP = 8'hFF; READY_DOWN = 1'b0;
        tick(); tick();
        RESET = 1'b0; VALID_UP = 1'b0;
        checks++; if (VALID_DOWN !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", VALID_DOWN); end
        checks++; if (READY_UP !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", READY_UP); end
        checks++; if (DATA_DOWN !== 8'h00) begin errors++; $display("FAIL reset_data: got %0h expected 0", DATA_DOWN); end
`ifdef HANDSHAKE_FIFO_LEVEL_EN
        checks++; if (LEVEL !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", LEVEL); end
`endif
        tick();
        checks++; if (VALID_DOWN !== 1'b0) begin errors++; $display("FAIL reset_no_capture: got %b expected 0", VALID_DOWN); end
    endtask

    task automatic test_single_word();
        VALID_UP = 1'b1; DATA_UP = 8'hA5; READY_DOWN = 1'b0;
        #1;
        checks++; if (VALID_DOWN !== 1'b0) begin errors++; $display("FAIL single_no_bypass: got %b expected 0", VALID_DOWN); end
        tick();
        VALID_UP = 1'b0;
        checks++; if (VALID_DOWN !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", VALID_DOWN); end
        checks++; if (DATA_DOWN !== 8'hA5) begin errors++; $display("FAIL single_data: got %0h expected a5", DATA_DOWN); end
        READY_DOWN = 1'b1;
        tick();
        READY_DOWN = 1'b0;
        checks++; if (VALID_DOWN !== 1'b0) begin errors++; $display("FAIL single_empty: got %b expected 0", VALID_DOWN); end
    endtask

    task automatic test_fill_to_full();
        READY_DOWN = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            VALID_UP = 1'b1; DATA_UP = 8'(i);
            tick();
            checks++;
            if (READY_UP !== (i < 4)) begin
                errors++; $display("FAIL fill_ready_%0d: got %b expected %b", i, READY_UP, (i < 4));
            end
        end
`ifdef HANDSHAKE_FIFO_LEVEL_EN
        checks++; if (LEVEL !== 3'd4) begin errors++; $display("FAIL fill_level: got %0d expected 4", LEVEL); end
`endif
        DATA_UP = 8'h05;
        tick();
        VALID_UP = 1'b0;
        checks++; if (READY_UP !== 1'b0) begin errors++; $display("FAIL fill_still_full: got %b expected 0", READY_UP); end
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (VALID_DOWN !== 1'b1 || DATA_DOWN !== 8'(i)) begin
                errors++; $display("FAIL fill_drain_%0d: got v=%b d=%0h expected v=1 d=%0h", i, VALID_DOWN, DATA_DOWN, i);
            end
            READY_DOWN = 1'b1;
            tick();
            READY_DOWN = 1'b0;
        end
        checks++; if (VALID_DOWN !== 1'b0) begin errors++; $display("FAIL fill_drained: got %b expected 0", VALID_DOWN); end
    endtask

    task automatic test_full_pop();
        READY_DOWN = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            VALID_UP = 1'b1; DATA_UP = 8'(8'h10 + i);
            tick();
        end
        DATA_UP = 8'h55; READY_DOWN = 1'b1;
        tick();
        VALID_UP = 1'b0; READY_DOWN = 1'b0;
        checks++; if (READY_UP !== 1'b1) begin errors++; $display("FAIL fullpop_ready: got %b expected 1", READY_UP); end
`ifdef HANDSHAKE_FIFO_LEVEL_EN
        checks++; if (LEVEL !== 3'd3) begin errors++; $display("FAIL fullpop_level: got %0d expected 3", LEVEL); end
`endif
        for (int i = 2; i <= 4; i++) begin
            checks++;
            if (VALID_DOWN !== 1'b1 || DATA_DOWN !== 8'(8'h10 + i)) begin
                errors++; $display("FAIL fullpop_drain_%0d: got v=%b d=%0h expected v=1 d=%0h", i, VALID_DOWN, DATA_DOWN, 8'h10 + i);
            end
            READY_DOWN = 1'b1;
            tick();
            READY_DOWN = 1'b0;
        end
        checks++; if (VALID_DOWN !== 1'b0) begin errors++; $display("FAIL fullpop_no_push: got %b expected 0", VALID_DOWN); end
    endtask

    task automatic test_back_to_back();
        int mism;
        mism = 0;
        for (int k = 0; k < 20; k++) begin
            VALID_UP = 1'b1; READY_DOWN = 1'b1; DATA_UP = 8'(k);
            if (k > 0) begin
                if (VALID_DOWN !== 1'b1 || DATA_DOWN !== 8'(k - 1) || READY_UP !== 1'b1) begin
                    mism++;
                    $display("FAIL stream_%0d: got v=%b d=%0h r=%b expected v=1 d=%0h r=1", k, VALID_DOWN, DATA_DOWN, READY_UP, k - 1);
                end
            end
            tick();
        end
        checks++; if (mism != 0) errors++;
        VALID_UP = 1'b0; READY_DOWN = 1'b0;
        checks++;
        if (VALID_DOWN !== 1'b1 || DATA_DOWN !== 8'h13) begin
            errors++; $display("FAIL stream_last: got v=%b d=%0h expected v=1 d=13", VALID_DOWN, DATA_DOWN);
        end
`ifdef HANDSHAKE_FIFO_LEVEL_EN
        checks++; if (LEVEL !== 3'd1) begin errors++; $display("FAIL stream_level: got %0d expected 1", LEVEL); end
`endif
        READY_DOWN = 1'b1;
        tick();
        READY_DOWN = 1'b0;
        checks++; if (VALID_DOWN !== 1'b0) begin errors++; $display("FAIL stream_empty: got %b expected 0", VALID_DOWN); end
    endtask

    task automatic test_mid_reset();
        READY_DOWN = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            VALID_UP = 1'b1; DATA_UP = 8'(8'h30 + i);
            tick();
        end
        VALID_UP = 1'b0;
`ifdef HANDSHAKE_FIFO_LEVEL_EN
        checks++; if (LEVEL !== 3'd3) begin errors++; $display("FAIL midrst_level_before: got %0d expected 3", LEVEL); end
`endif
        chk("midrst_head_before", DATA_DOWN, 8'h31);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        checks++; if (VALID_DOWN !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", VALID_DOWN); end
        chk("midrst_data", DATA_DOWN, 8'h00);
`ifdef HANDSHAKE_FIFO_LEVEL_EN
        checks++; if (LEVEL !== 3'd0) begin errors++; $display("FAIL midrst_level: got %0d expected 0", LEVEL); end
`endif
        VALID_UP = 1'b1; DATA_UP = 8'h7E;
        tick();
        VALID_UP = 1'b0;
        checks++; if (VALID_DOWN !== 1'b1) begin errors++; $display("FAIL midrst_new_valid: got %b expected 1", VALID_DOWN); end
        chk("midrst_new_data", DATA_DOWN, 8'h7E);
        READY_DOWN = 1'b1;
        tick();
        READY_DOWN = 1'b0;
        checks++; if (VALID_DOWN !== 1'b0) begin errors++; $display("FAIL midrst_empty: got %b expected 0", VALID_DOWN); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        RESET = 1'b0; VALID_UP = 1'b0; DATA_UP = 8'h00; READY_DOWN = 1'b0;
        test_reset();
        test_single_word();
        test_fill_to_full();
        test_full_pop();
        test_back_to_back();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/handshake_fifo.md
Name: handshake_fifo

Overview:
- Parameterised synchronous FIFO placed directly downstream of the single-register valid/ready stage; it consumes that stage's VALID_DOWN/DATA_DOWN output.
- Absorbs back-pressure bursts so the register stage sees READY asserted for up to DEPTH words while the consumer stalls.
- Uses the same valid/ready protocol on both sides. No combinational path exists from READY_DOWN to READY_UP.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 4, number of storage entries; must be a power of 2 and at least 2.
- ADDR_W, $clog2(DEPTH), pointer index width; derived, never overridden.

Ports:
- CLK  input  1  rising-edge clock.
- RESET  input  1  synchronous reset, active-high.
- VALID_UP  input  1  upstream word valid.
- READY_UP  output  1  FIFO can accept a word this cycle.
- DATA_UP  input  WIDTH  upstream data.
- VALID_DOWN  output  1  FIFO holds at least one word.
- READY_DOWN  input  1  downstream accepts the word this cycle.
- DATA_DOWN  output  WIDTH  head-of-FIFO data.
- LEVEL  output  ADDR_W+1  occupancy, 0..DEPTH; present only with HANDSHAKE_FIFO_LEVEL_EN.

Behaviour:
- Clocking and reset: one clock, CLK. Reset is synchronous and active-high on RESET, sampled on the CLK rising edge.
- Reset values:
  - wr_ptr, rd_ptr and count are 0.
  - All memory entries are 0.
  - VALID_DOWN = 0, READY_UP = 1, DATA_DOWN = 0, LEVEL = 0.
- Reset mid-operation discards all stored words. The cycle after RESET, the FIFO is empty.
- Push = VALID_UP && READY_UP. Pop = VALID_DOWN && READY_DOWN.
- READY_UP = (count != DEPTH). It is a function of registered state only.
- VALID_DOWN = (count != 0), also from registered state only.
- DATA_DOWN = mem[rd_ptr] (first-word fall-through, combinational read of the register array). It is don't-care while VALID_DOWN = 0, except immediately after reset.
- Latency: a word pushed in cycle N appears on DATA_DOWN with VALID_DOWN = 1 in cycle N+1 at the earliest. There is no same-cycle bypass, even when the FIFO is empty.
- Push only: mem[wr_ptr] <= DATA_UP, wr_ptr +1, count +1.
- Pop only: rd_ptr +1, count -1.
- Push and pop in the same cycle:
  - Both pointers advance and count is unchanged.
  - Legal at any count from 1 to DEPTH-1.
  - At count = 0, a pop is impossible (VALID_DOWN = 0).
  - At count = DEPTH, a push is impossible (READY_UP = 0), even if READY_DOWN = 1 that cycle.
- Pointers are ADDR_W bits and wrap modulo DEPTH (DEPTH-1 + 1 = 0). count is ADDR_W+1 bits, so DEPTH is representable.
- Protocol:
  - Once VALID_DOWN = 1, the FIFO holds DATA_DOWN stable until a pop occurs.
  - VALID_UP/DATA_UP held without READY_UP are simply not captured.
  - Ordering is strictly FIFO. No word is dropped or duplicated.
- Boundaries:
  - Full: READY_UP drops in the cycle after the DEPTH-th push.
  - Empty: VALID_DOWN drops in the cycle after the last pop.

Optional Feature:
- Macro: HANDSHAKE_FIFO_LEVEL_EN.
- Defined: the LEVEL port exists and equals count, registered with zero extra latency (it is count itself).
- Undefined: the LEVEL port is absent. Behaviour is otherwise identical.

Decomposition:
- Shared package handshake_pkg holds:
  - default WIDTH and DEPTH constants;
  - the ptr_t/count_t width helpers, derived from ADDR_W;
  - a common clog2 function shared with other handshake stages.
- One sub-module, fifo_ptr: a wrapping ADDR_W-bit pointer register with synchronous active-high reset and an increment enable. It is instantiated twice, for write and read.
- The memory array and count logic stay in handshake_fifo.

Test Plan:
- Reset: assert RESET 2 cycles with VALID_UP = 1 -> VALID_DOWN = 0, READY_UP = 1, DATA_DOWN = 0, LEVEL = 0; no word captured.
- Single word: push 0xA5 in cycle N with READY_DOWN = 0 -> VALID_DOWN = 1, DATA_DOWN = 0xA5 at N+1; with READY_DOWN = 1 at N+1, the FIFO is empty at N+2.
- Fill to full: READY_DOWN = 0, push 0x01..0x04 -> READY_UP = 0 after the 4th push, LEVEL = 4; 0x05 presented is not taken; then drain gives 0x01,0x02,0x03,0x04 in order.
- Full with simultaneous READY_DOWN: count = 4, VALID_UP = 1, READY_DOWN = 1 -> one pop, no push; LEVEL = 3 next cycle, READY_UP = 1.
- Wrap-around streaming: VALID_UP = READY_DOWN = 1 for 20 cycles with an incrementing pattern 0x00..0x13 -> output is identical in order, count steady at 1, pointers wrap 5 times.
- Mid-operation reset: count = 3, assert RESET one cycle -> next cycle VALID_DOWN = 0, LEVEL = 0; a new push 0x7E is the first word out.
